// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN host link: FSM states, frame size, ASCII digit range.
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT_TX,
    WAIT_RESP
  } state_t;

  localparam int         FRAME_LEN_DEF = 784;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_NINE    = 8'h39;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/snn_host_tx.sv
// Streams one image frame byte-per-pixel to uart_tx, then waits for the ASCII digit answer from uart_rx.
// Per byte: FETCH, SEND, one guard cycle, then uart byte time; SEND stalls while tx_rdy is low.
module snn_host_tx
  import snn_pkg::*;
#(
  parameter int FRAME_LEN    = FRAME_LEN_DEF,
  parameter int RESP_TIMEOUT = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic [9:0] pix_addr,
  input  logic       pix_q,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_rdy,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic [3:0] result,
  output logic       result_vld,
  output logic       err
);

  localparam int          TW        = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [9:0]  LAST_ADDR = 10'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(RESP_TIMEOUT - 1);

  state_t        state;
  logic          tx_guard;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      pix_addr   <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      result     <= '0;
      result_vld <= 1'b0;
      err        <= 1'b0;
      tx_guard   <= 1'b0;
      to_cnt     <= '0;
    end else begin
      tx_start   <= 1'b0;
      result_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pix_addr <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          tx_data <= {7'b0, pix_q};
          state   <= SEND;
        end
        SEND: begin
          if (tx_rdy) begin
            tx_start <= 1'b1;
            tx_guard <= 1'b1;
            state    <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          // uart_tx may still show idle on the cycle right after tx_start
          if (tx_guard) begin
            tx_guard <= 1'b0;
          end else if (tx_rdy) begin
            if (pix_addr == LAST_ADDR) begin
              to_cnt <= '0;
              state  <= WAIT_RESP;
            end else begin
              pix_addr <= pix_addr + 10'd1;
              state    <= FETCH;
            end
          end
        end
        WAIT_RESP: begin
          if (rx_rdy) begin
            if (is_digit(rx_data)) begin
              // low nibble of ASCII '0'..'9' is the digit itself
              result     <= rx_data[3:0];
              result_vld <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/snn_host_tx.md
SNN_HOST_TX -- requirements
Module: snn_host_tx

Interface
REQ-001 Parameter FRAME_LEN, default 784: bytes per image frame, one pixel per byte.
REQ-002 Parameter RESP_TIMEOUT, default 50_000_000: cycles to wait for the result byte before flagging an error.
REQ-003 Port clk, input, 1: single system clock; all logic on posedge clk.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low; already synchronized externally.
REQ-005 Port start, input, 1: one-cycle pulse that requests transmission of one frame.
REQ-006 Port busy, output, 1: high from accepted start until result_vld or err.
REQ-007 Port pix_addr, output, 10: pixel memory read address.
REQ-008 Port pix_q, input, 1: pixel memory data, valid exactly one cycle after pix_addr changes.
REQ-009 Port tx_start, output, 1: one-cycle pulse to uart_tx.
REQ-010 Port tx_data, output, 8: byte to uart_tx, held stable from tx_start until tx_rdy returns high.
REQ-011 Port tx_rdy, input, 1: uart_tx idle flag; falls within 1 cycle of tx_start.
REQ-012 Port rx_rdy, input, 1: uart_rx byte-received pulse.
REQ-013 Port rx_data, input, 8: uart_rx received byte, valid while rx_rdy is high.
REQ-014 Port result, output, 4: decoded digit 0-9 returned by the SNN.
REQ-015 Port result_vld, output, 1: one-cycle pulse when result updates.
REQ-016 Port err, output, 1: sticky error flag (bad response byte or timeout); cleared by the next accepted start.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, SEND, WAIT_TX, WAIT_RESP.
REQ-018 In IDLE, start=1 SHALL clear pix_addr and err, assert busy, and go to FETCH; start SHALL be ignored outside IDLE.
REQ-019 In FETCH (1 cycle), the FSM SHALL capture tx_data = {7'b0, pix_q} and go to SEND.
REQ-020 SEND SHALL assert tx_start for exactly one cycle, then go to WAIT_TX, provided tx_rdy=1; while tx_rdy=0 it SHALL hold in SEND without asserting tx_start.
REQ-021 WAIT_TX SHALL ignore tx_rdy on its first cycle (guard for the uart_tx drop latency), then wait for tx_rdy=1.
REQ-022 On tx_rdy=1 in WAIT_TX: if pix_addr==FRAME_LEN-1, the FSM SHALL clear the timeout counter and go to WAIT_RESP; otherwise it SHALL increment pix_addr and go to FETCH.
REQ-023 pix_addr SHALL never exceed FRAME_LEN-1 and SHALL NOT wrap during a frame.
REQ-024 rx_rdy pulses outside WAIT_RESP SHALL be ignored.
REQ-025 In WAIT_RESP, rx_rdy=1 with rx_data in 8'h30..8'h39 SHALL set result=rx_data-8'h30, pulse result_vld, deassert busy, and return to IDLE.
REQ-026 In WAIT_RESP, rx_rdy=1 with any other rx_data SHALL set err, leave result unchanged, deassert busy, and return to IDLE.
REQ-027 The timeout counter SHALL increment every WAIT_RESP cycle; reaching RESP_TIMEOUT-1 without rx_rdy SHALL set err and return to IDLE.
REQ-028 If rx_rdy and the timeout occur in the same cycle, rx_rdy SHALL take priority.
REQ-029 Frame latency SHALL be FRAME_LEN*(3 + uart byte time) cycles, plus the response time.

Reset
REQ-030 Asserting rst_n low SHALL immediately force IDLE, with busy=0, tx_start=0, tx_data=0, pix_addr=0, result=0, result_vld=0, err=0, and timeout counter=0.
REQ-031 Reset mid-frame SHALL abandon the frame; no tx_start SHALL follow until a new start is accepted after reset release.

Structure
REQ-032 A shared package snn_pkg SHALL hold the state enum, FRAME_LEN default, and ASCII_ZERO=8'h30.
REQ-033 The block SHALL be a single module with no sub-modules; uart_tx and uart_rx are instantiated beside it by the parent, unmodified.
REQ-034 The timeout counter SHALL be sized as $clog2(RESP_TIMEOUT) bits.

Verification
REQ-035 Normal frame: FRAME_LEN=784, alternating pix_q, uart_tx model, then rx byte 8'h37 -> 784 tx_start pulses, tx_data bytes 00/01 matching memory, result=7, one result_vld pulse, busy low.
REQ-036 Bad response: after frame, rx_data=8'h41 -> err=1, result keeps its prior value, no result_vld.
REQ-037 Timeout: RESP_TIMEOUT=100, no rx_rdy -> err=1 exactly 100 cycles after WAIT_RESP entry; busy=0.
REQ-038 Backpressure and stray input: tx_rdy held low 20 cycles at byte 5, plus rx_rdy pulse mid-frame -> no extra tx_start, byte order intact, stray byte ignored.
REQ-039 Reset at pix_addr=300 -> all outputs zero within the same cycle; new start sends byte 0 first.
REQ-040 start pulsed while busy -> ignored; only one frame of 784 bytes is sent.
